// File: rtl/mips_pkg.sv
// Shared definitions for the mipscpu front end.
//   - Opcode field values (bits [31:26]) used by the datapath decoder.
//   - Default halt encoding for the fetch unit.
//   - fetch_state_t: the fetch controller's state set.
//   - next_pc(): sequential / taken-branch program counter arithmetic.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_BEQ   = 6'd4;

    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        FS_IDLE,
        FS_FETCH,
        FS_ISSUE,
        FS_RESOLVE,
        FS_HALT,
        FS_FAULT
    } fetch_state_t;

    // beq target: pc + 4 + (offset << 2), everything modulo 2^32.
    function automatic logic [31:0] next_pc(input logic [31:0] pc,
                                            input logic        taken,
                                            input logic [31:0] offset);
        logic [31:0] step;
        step = taken ? {offset[29:0], 2'b00} : 32'd0;
        return pc + 32'd4 + step;
    endfunction

endpackage

// File: rtl/instr_rom.sv
// Instruction memory: DEPTH x 32-bit words.
//   clk_i      rising-edge clock
//   rst_ni     asynchronous active-low reset (read data register only)
//   rd_en_i    read enable; rd_data_o updates only when set
//   rd_addr_i  word read address
//   rd_data_o  registered read data (holds between reads)
//   wr_en_i    load write enable
//   wr_addr_i  word write address
//   wr_data_i  word to write
// The array itself is never reset so a program survives a CPU reset.
module instr_rom #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [31:0]       rd_data_o,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [31:0]       wr_data_i
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // The read register doubles as the fetched-instruction register, so it
    // clears on reset even though the array does not.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_data_q <= 32'd0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage for the single-cycle mipscpu datapath.
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   start                 begin fetching (IDLE) or restart from RESET_PC (HALT)
//   stall                 hold the PC update while in RESOLVE
//   branch, zero,
//   branch_offset         beq resolution inputs for the issued instruction
//   load_en, load_addr,
//   load_data             program load port, honoured only in IDLE
//   instrword, newinstr   fetched word and its one-cycle valid pulse
//   pc, pc_plus4          address of instrword and that address + 4
//   halted, fault         stopped in HALT/FAULT; fault only in FAULT
// Each instruction spends one cycle each in FETCH, ISSUE and RESOLVE
// (RESOLVE extends while stalled).
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 64,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD  = HALT_WORD_DEFAULT
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          stall,
    input  logic                          branch,
    input  logic                          zero,
    input  logic [31:0]                   branch_offset,
    input  logic                          load_en,
    input  logic [$clog2(IMEM_DEPTH)-1:0] load_addr,
    input  logic [31:0]                   load_data,
    output logic [31:0]                   instrword,
    output logic                          newinstr,
    output logic [31:0]                   pc,
    output logic [31:0]                   pc_plus4,
    output logic                          halted,
    output logic                          fault
);

    localparam int unsigned ADDR_W = $clog2(IMEM_DEPTH);

    fetch_state_t state_q;
    logic [31:0]  pc_q;
    logic         halted_q;
    logic         fault_q;

    logic         pc_valid;
    logic         rom_rd_en;
    logic         rom_wr_en;
    logic [31:0]  rom_rd_data;

    // A PC is fetchable only if word aligned and inside the memory.
    assign pc_valid  = (pc_q[1:0] == 2'b00) && (pc_q[31:2] < 30'(IMEM_DEPTH));
    assign rom_rd_en = (state_q == FS_FETCH) && pc_valid;
    assign rom_wr_en = (state_q == FS_IDLE) && load_en;

    instr_rom #(
        .DEPTH  (IMEM_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_rom (
        .clk_i     (clock),
        .rst_ni    (reset),
        .rd_en_i   (rom_rd_en),
        .rd_addr_i (pc_q[ADDR_W+1:2]),
        .rd_data_o (rom_rd_data),
        .wr_en_i   (rom_wr_en),
        .wr_addr_i (load_addr),
        .wr_data_i (load_data)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= FS_IDLE;
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            case (state_q)
                FS_IDLE: begin
                    // A load in the same cycle wins; start must be re-issued.
                    if (start && !load_en) begin
                        state_q <= FS_FETCH;
                    end
                end
                FS_FETCH: begin
                    if (pc_valid) begin
                        state_q <= FS_ISSUE;
                    end else begin
                        state_q  <= FS_FAULT;
                        halted_q <= 1'b1;
                        fault_q  <= 1'b1;
                    end
                end
                FS_ISSUE: begin
                    if (rom_rd_data == HALT_WORD) begin
                        state_q  <= FS_HALT;
                        halted_q <= 1'b1;
                    end else begin
                        state_q <= FS_RESOLVE;
                    end
                end
                FS_RESOLVE: begin
                    if (!stall) begin
                        pc_q    <= next_pc(pc_q, branch & zero, branch_offset);
                        state_q <= FS_FETCH;
                    end
                end
                FS_HALT: begin
                    if (start) begin
                        pc_q     <= RESET_PC;
                        halted_q <= 1'b0;
                        state_q  <= FS_FETCH;
                    end
                end
                FS_FAULT: begin
                    // Sticky until reset.
                end
                default: begin
                    state_q  <= FS_IDLE;
                    halted_q <= 1'b0;
                    fault_q  <= 1'b0;
                end
            endcase
        end
    end

    // The halt word is never presented as a valid instruction.
    assign newinstr  = (state_q == FS_ISSUE) && (rom_rd_data != HALT_WORD);
    assign instrword = rom_rd_data;
    assign pc        = pc_q;
    assign pc_plus4  = pc_q + 32'd4;
    assign halted    = halted_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    localparam int unsigned DEPTH = 64;
    localparam logic [31:0] HALT  = 32'hFFFF_FFFF;
    localparam logic [31:0] BEQ0  = 32'h1000_0003;

    logic        clock;
    logic        reset;
    logic        start;
    logic        stall;
    logic        branch;
    logic        zero;
    logic [31:0] branch_offset;
    logic        load_en;
    logic [5:0]  load_addr;
    logic [31:0] load_data;
    logic [31:0] instrword;
    logic        newinstr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        halted;
    logic        fault;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model_mem [DEPTH];

    typedef struct {
        logic        br;
        logic        zr;
        logic [31:0] off;
        logic [31:0] exp_pc;
        logic        exp_fault;
    } vec_t;

    vec_t tbl [8];

    instr_fetch_unit #(
        .IMEM_DEPTH (DEPTH),
        .RESET_PC   (32'h0000_0000),
        .HALT_WORD  (HALT)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .stall         (stall),
        .branch        (branch),
        .zero          (zero),
        .branch_offset (branch_offset),
        .load_en       (load_en),
        .load_addr     (load_addr),
        .load_data     (load_data),
        .instrword     (instrword),
        .newinstr      (newinstr),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .halted        (halted),
        .fault         (fault)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clock);
        #3;
        reset = 1'b0;
        #3;
        reset = 1'b1;
        tick();
    endtask

    task automatic load(input int addr, input logic [31:0] data);
        load_en   = 1'b1;
        load_addr = 6'(addr);
        load_data = data;
        tick();
        load_en   = 1'b0;
        model_mem[addr] = data;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Advance until an instruction issues or fetch stops; bounded.
    task automatic wait_event(output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!newinstr && !halted && cycles < 20);
    endtask

    initial begin
        int          cyc;
        int          k;
        int          kind;   // 0 issue, 1 halt, 2 fault
        int          base;
        int          tgt;
        logic [31:0] model_pc;
        logic [31:0] diff;
        logic        b;
        logic        z;
        logic [31:0] off;
        logic [31:0] w;

        reset = 1'b0; start = 1'b0; stall = 1'b0; branch = 1'b0; zero = 1'b0;
        branch_offset = 32'd0; load_en = 1'b0; load_addr = 6'd0; load_data = 32'd0;
        #12;
        check("rst_pc", pc, 32'h0);
        check("rst_pc4", pc_plus4, 32'h4);
        check("rst_word", instrword, 32'h0);
        check("rst_new", 32'(newinstr), 32'h0);
        check("rst_halt", 32'(halted), 32'h0);
        check("rst_fault", 32'(fault), 32'h0);
        reset = 1'b1;
        tick();

        // Background program: beq at word 0, distinct filler elsewhere.
        for (int i = 0; i < DEPTH; i++) load(i, (i == 0) ? BEQ0 : 32'h2000_0000 + 32'(i));

        // Branch resolution vectors: {branch, zero, offset, next pc, faults}.
        tbl[0] = '{1'b1, 1'b1, 32'd3,          32'h0000_0010, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 32'd3,          32'h0000_0004, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 32'd3,          32'h0000_0004, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 32'd0,          32'h0000_0004, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 32'd1,          32'h0000_0008, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 32'd60,         32'h0000_00F4, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 32'd63,         32'h0000_0100, 1'b1};
        tbl[7] = '{1'b1, 1'b1, 32'hFFFF_FFFE,  32'hFFFF_FFFC, 1'b1};

        for (int v = 0; v < 8; v++) begin
            do_reset();
            start_pulse();
            tick();
            check("tbl_new0", 32'(newinstr), 32'h1);
            check("tbl_pc0", pc, 32'h0);
            branch = tbl[v].br; zero = tbl[v].zr; branch_offset = tbl[v].off;
            tick();
            tick();
            branch = 1'b0; zero = 1'b0; branch_offset = 32'd0;
            check("tbl_pc_fetch", pc, tbl[v].exp_pc);
            tick();
            if (tbl[v].exp_fault) begin
                check("tbl_fault", 32'(fault), 32'h1);
                check("tbl_halted", 32'(halted), 32'h1);
                check("tbl_new_f", 32'(newinstr), 32'h0);
            end else begin
                check("tbl_new1", 32'(newinstr), 32'h1);
                check("tbl_word", instrword, model_mem[tbl[v].exp_pc[7:2]]);
            end
            check("tbl_pc", pc, tbl[v].exp_pc);
            $display("vec %0d br=%0b zr=%0b off=%h pc=%h fault=%0b", v, tbl[v].br, tbl[v].zr,
                     tbl[v].off, pc, fault);
        end

        // Wrapped target faults; start is ignored; reset recovers.
        do_reset();
        start_pulse();
        tick();
        branch = 1'b1; zero = 1'b1; branch_offset = 32'hFFFF_FFFE;
        tick(); tick(); tick();
        branch = 1'b0; zero = 1'b0; branch_offset = 32'd0;
        start = 1'b1; tick(); tick(); start = 1'b0; tick();
        check("flt_fault", 32'(fault), 32'h1);
        check("flt_halted", 32'(halted), 32'h1);
        check("flt_pc", pc, 32'hFFFF_FFFC);
        do_reset();
        check("flt_rst_fault", 32'(fault), 32'h0);
        check("flt_rst_halted", 32'(halted), 32'h0);
        check("flt_rst_pc", pc, 32'h0);
        $display("fault sequence done pc=%h", pc);

        // Four stall cycles in RESOLVE hold everything.
        start_pulse();
        tick();
        stall = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stl_pc", pc, 32'h0);
            check("stl_word", instrword, model_mem[0]);
            check("stl_new", 32'(newinstr), 32'h0);
        end
        stall = 1'b0;
        tick();
        check("stl_rel_new0", 32'(newinstr), 32'h0);
        tick();
        check("stl_rel_new1", 32'(newinstr), 32'h1);
        check("stl_rel_pc", pc, 32'h4);
        check("stl_rel_word", instrword, model_mem[1]);
        $display("stall sequence done pc=%h", pc);

        // Asynchronous reset while stalled in RESOLVE of the second instruction.
        do_reset();
        start_pulse();
        tick(); tick(); tick(); tick();
        check("ar_pc4", pc, 32'h4);
        stall = 1'b1;
        tick(); tick();
        #2;
        reset = 1'b0;
        #1;
        check("ar_pc", pc, 32'h0);
        check("ar_word", instrword, 32'h0);
        check("ar_new", 32'(newinstr), 32'h0);
        check("ar_halted", 32'(halted), 32'h0);
        stall = 1'b0;
        #2;
        reset = 1'b1;
        tick();
        start_pulse();
        tick();
        check("ar_re_new", 32'(newinstr), 32'h1);
        check("ar_re_word", instrword, model_mem[0]);
        $display("async reset sequence done word=%h", instrword);

        // Short program ending in the halt word.
        do_reset();
        load(0, 32'h0109_5020);
        load(1, 32'h8D28_0004);
        load(2, HALT);
        start = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            start = 1'b0;
            check("prg_new", 32'(newinstr), 32'((c == 2) || (c == 5)));
            if (c == 2) begin
                check("prg_w0", instrword, 32'h0109_5020);
                check("prg_pc0", pc, 32'h0);
            end
            if (c == 5) begin
                check("prg_w1", instrword, 32'h8D28_0004);
                check("prg_pc1", pc, 32'h4);
            end
        end
        check("prg_halted", 32'(halted), 32'h1);
        check("prg_fault", 32'(fault), 32'h0);
        check("prg_pc", pc, 32'h8);
        $display("program sequence done pc=%h halted=%0b", pc, halted);

        // load_en and start together: load wins, stays IDLE.
        do_reset();
        load_en = 1'b1; load_addr = 6'd0; load_data = 32'h0123_4567; start = 1'b1;
        tick();
        load_en = 1'b0; start = 1'b0;
        model_mem[0] = 32'h0123_4567;
        tick();
        check("ls_new_a", 32'(newinstr), 32'h0);
        tick();
        check("ls_new_b", 32'(newinstr), 32'h0);
        start_pulse();
        tick();
        check("ls_new", 32'(newinstr), 32'h1);
        check("ls_word", instrword, 32'h0123_4567);
        $display("load-vs-start sequence done word=%h", instrword);

        // Randomised run against a transaction-level model.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            w = $urandom;
            if (i != 0 && $urandom_range(0, 15) == 0) w = HALT;
            if (w == HALT && i == 0) w = 32'h0;
            load(i, w);
        end
        start_pulse();
        model_pc = 32'h0;
        base = 0;
        for (int t = 0; t < 200; t++) begin
            if (model_pc % 4 != 0 || model_pc / 4 >= DEPTH) kind = 2;
            else if (model_mem[model_pc / 4] == HALT)       kind = 1;
            else                                            kind = 0;
            wait_event(cyc);
            check("rnd_lat", 32'(cyc), 32'(base + ((kind == 1) ? 2 : 1)));
            check("rnd_pc", pc, model_pc);
            check("rnd_fault", 32'(fault), 32'(kind == 2));
            check("rnd_halted", 32'(halted), 32'(kind != 0));
            if (kind == 0) begin
                check("rnd_word", instrword, model_mem[model_pc / 4]);
                b = 1'($urandom_range(0, 1));
                z = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 9) < 8) begin
                    tgt  = $urandom_range(0, DEPTH - 1);
                    diff = 32'(tgt * 4) - model_pc - 32'd4;
                    off  = {{2{diff[31]}}, diff[31:2]};
                end else begin
                    off = $urandom;
                end
                k = $urandom_range(0, 3);
                $display("txn %0d pc=%h word=%h br=%0b zr=%0b off=%h stall=%0d", t, pc,
                         instrword, b, z, off, k);
                branch = b; zero = z; branch_offset = off;
                stall = (k > 0);
                tick();
                repeat (k) tick();
                stall = 1'b0;
                model_pc = model_pc + 32'd4 + ((b && z) ? off * 32'd4 : 32'd0);
                base = 1;
            end else begin
                $display("txn %0d stop pc=%h kind=%0d", t, pc, kind);
                if (kind == 2) do_reset();
                start_pulse();
                model_pc = 32'h0;
                base = 0;
            end
        end
        branch = 1'b0; zero = 1'b0; branch_offset = 32'd0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
